larng_sample_ctrl: RTL and testbench

//  Sequencer for the latch-based entropy cell in the user project wrapper.

---
 rtl/larng_pkg.sv | 15 +
 rtl/larng_sample_ctrl_if.sv | 11 +
 rtl/larng_word_fifo.sv | 54 +++++
 rtl/larng_sample_ctrl.sv | 162 ++++++++++++++++
 tb/tb_larng_sample_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/larng_pkg.sv
// Shared types and constants for the latch-based entropy sampler.
package larng_pkg;

  localparam int WORD_W   = 32;
  localparam int BITCNT_W = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    PUSH   = 3'd3,
    FAIL   = 3'd4
  } state_t;

endpackage

// File: rtl/larng_sample_ctrl_if.sv
// Word readout stream: master presents buffered words, slave pops them.
interface larng_sample_ctrl_if;

  logic [larng_pkg::WORD_W-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/larng_word_fifo.sv
// DEPTH x WORD_W first-word-fall-through buffer for packed entropy words.
module larng_word_fifo
  import larng_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       resetb,
  input  logic                       push,
  input  logic [WORD_W-1:0]          wdata,
  input  logic                       pop,
  output logic [WORD_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/larng_sample_ctrl.sv
// Sequencer for the latch entropy cell: gate, settle, sample, health-test, pack, buffer.
module larng_sample_ctrl
  import larng_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SETTLE_W = 16,
  parameter int DIV_W    = 8,
  parameter int RCT_W    = 6
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                cfg_en,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [RCT_W-1:0]    cfg_rct_cut,
  input  logic                clr_fail,
  input  logic                ent_bit,
  output logic                ent_run,
  larng_sample_ctrl_if.master out_if,
  output logic                health_fail,
  output logic                busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t              state, state_nx;
  logic                sync1, sync2, sample;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [BITCNT_W-1:0] bit_cnt;
  logic [WORD_W-1:0]   word;
  logic [RCT_W-1:0]    rep_cnt, rep_nx;
  logic                prev_bit, first_smp;
  logic                sample_tick, rct_trip, last_bit;
  logic                fifo_push, fifo_full, fifo_empty, pop_fire, full_after;
  logic [CW-1:0]       fifo_count;

  assign sample           = sync2;
  assign out_if.out_valid = !fifo_empty;

  larng_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .resetb (resetb),
    .push   (fifo_push),
    .wdata  (word),
    .pop    (out_if.out_ready),
    .rdata  (out_if.out_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Sample strobe, repetition-count update and trip/fill conditions.
  always_comb begin
    sample_tick = (state == SAMPLE) && (div_cnt == '0);
    if (first_smp)                    rep_nx = RCT_W'(1);
    else if (sample == prev_bit)      rep_nx = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
    else                              rep_nx = RCT_W'(1);
    rct_trip   = sample_tick && (cfg_rct_cut != '0) && (rep_nx == cfg_rct_cut);
    last_bit   = sample_tick && (bit_cnt == '1);
    pop_fire   = out_if.out_valid && out_if.out_ready;
    // PUSH is never entered full, so a concurrent pop always keeps it below full.
    full_after = !pop_fire && (fifo_count == CW'(DEPTH - 1));
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_nx  = state;
    ent_run   = 1'b0;
    busy      = 1'b0;
    fifo_push = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_en && !health_fail && !fifo_full) state_nx = SETTLE;
      end
      SETTLE: begin
        ent_run = 1'b1;
        busy    = 1'b1;
        if (!cfg_en)                 state_nx = IDLE;
        else if (settle_cnt == '0)   state_nx = SAMPLE;
      end
      SAMPLE: begin
        ent_run = 1'b1;
        busy    = 1'b1;
        if (!cfg_en)       state_nx = IDLE;
        else if (rct_trip) state_nx = FAIL;
        else if (last_bit) state_nx = PUSH;
      end
      PUSH: begin
        ent_run   = 1'b1;
        busy      = 1'b1;
        fifo_push = 1'b1;
        if (!cfg_en || full_after) state_nx = IDLE;
        else                       state_nx = SAMPLE;
      end
      FAIL: begin
        if (clr_fail) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and sticky health flag (held exactly while in FAIL).
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      health_fail <= 1'b0;
    end else begin
      state       <= state_nx;
      health_fail <= (state_nx == FAIL);
    end
  end

  // Synchronizer, counters, word shifter and repetition tracking.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      settle_cnt <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      rep_cnt    <= '0;
      prev_bit   <= 1'b0;
      first_smp  <= 1'b0;
    end else begin
      sync1 <= ent_bit;
      sync2 <= sync1;
      case (state)
        IDLE: begin
          settle_cnt <= cfg_settle;
          bit_cnt    <= '0;
          word       <= '0;
          first_smp  <= 1'b1;
        end
        SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
          div_cnt   <= cfg_div;
          first_smp <= 1'b1;
        end
        SAMPLE: begin
          if (div_cnt == '0) begin
            div_cnt   <= cfg_div;
            word      <= {sample, word[WORD_W-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            prev_bit  <= sample;
            rep_cnt   <= rep_nx;
            first_smp <= 1'b0;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        PUSH: begin
          bit_cnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_larng_sample_ctrl.sv
// Directed bench for larng_sample_ctrl with a sample-timeline word model and FIFO scoreboard.
module tb_larng_sample_ctrl;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        resetb;
  logic        cfg_en;
  logic [15:0] cfg_settle;
  logic [7:0]  cfg_div;
  logic [5:0]  cfg_rct_cut;
  logic        clr_fail;
  logic        ent_bit;
  logic        ent_run;
  logic        health_fail;
  logic        busy;

  larng_sample_ctrl_if bus ();

  larng_sample_ctrl #(
    .DEPTH    (DEPTH),
    .SETTLE_W (16),
    .DIV_W    (8),
    .RCT_W    (6)
  ) dut (
    .clock       (clock),
    .resetb      (resetb),
    .cfg_en      (cfg_en),
    .cfg_settle  (cfg_settle),
    .cfg_div     (cfg_div),
    .cfg_rct_cut (cfg_rct_cut),
    .clr_fail    (clr_fail),
    .ent_bit     (ent_bit),
    .ent_run     (ent_run),
    .out_if      (bus),
    .health_fail (health_fail),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          tests = 0;
  int          fails = 0;
  int          mode  = 0;
  logic [31:0] exp_q [$];

  // Entropy source pattern as a pure function of the edge count.
  function automatic logic pat(int m, int c);
    logic [31:0] h;
    h = 32'(c) * 32'h9E37_79B1;
    case (m)
      0:       return 1'(c & 1);
      1:       return 1'b1;
      default: return h[17];
    endcase
  endfunction

  // Word w of a run armed after edge c0: sample n lands on edge
  // c0+s+d+3+n*(d+1)+w and sees the bit driven three edges earlier.
  function automatic logic [31:0] exp_word(int c0, int s, int d, int w);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) begin
      int n, e;
      n    = 32 * w + k;
      e    = c0 + s + d + 3 + n * (d + 1) + w;
      r[k] = pat(mode, e - 3);
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic at_edge(int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_drain(string name, int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clock);
      #1;
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d words still outstanding, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    ent_bit = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      ent_bit = pat(mode, cyc);
    end
  end

  // Every-cycle comparison against the scoreboard and output relations.
  always @(negedge clock) begin
    if (resetb) begin
      tests++;
      if (ent_run !== busy || (health_fail && ent_run)) begin
        fails++;
        $display("FAIL run_busy: ent_run=%b busy=%b health_fail=%b, expected ent_run==busy and not both run and fail",
                 ent_run, busy, health_fail);
      end
      if (bus.out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word: got %h, expected no word", bus.out_data);
        end else begin
          if (bus.out_data !== exp_q[0]) begin
            fails++;
            $display("FAIL word_data: got %h, expected %h", bus.out_data, exp_q[0]);
          end
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int c0, c1, p, f, k, lat;
    resetb        = 1'b0;
    cfg_en        = 1'b0;
    cfg_settle    = '0;
    cfg_div       = '0;
    cfg_rct_cut   = '0;
    clr_fail      = 1'b0;
    bus.out_ready = 1'b0;
    mode          = 0;

    // Reset with toggling entropy input
    at_edge(4);
    check("rst_ent_run", 32'(ent_run), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_health_fail", 32'(health_fail), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_data", bus.out_data, 0);
    resetb = 1'b1;
    at_edge(cyc + 2);

    // Packing order with alternating bits, divider 0
    mode = 0; cfg_settle = 16'd3; cfg_div = 8'd0; cfg_rct_cut = '0;
    bus.out_ready = 1'b1;
    at_edge(cyc + 2);
    if (cyc % 2 != 0) at_edge(cyc + 1);
    c0 = cyc;
    exp_q.push_back(exp_word(c0, 3, 0, 0));
    exp_q.push_back(exp_word(c0, 3, 0, 1));
    check("model_w0", exp_q[0], 32'h5555_5555);
    check("model_w1", exp_q[1], 32'hAAAA_AAAA);
    cfg_en = 1'b1;
    k = 0;
    while (!bus.out_valid && k < 200) begin
      @(posedge clock);
      #1;
      k++;
    end
    lat = cyc - c0;
    tests++;
    if (lat < 38 || lat > 40) begin
      fails++;
      $display("FAIL first_latency: got %0d cycles, expected 38..40", lat);
    end
    check("first_word", bus.out_data, 32'h5555_5555);
    wait_drain("pack_drain", 200);
    cfg_en = 1'b0;
    at_edge(cyc + 3);
    check("pack_idle_busy", 32'(busy), 0);

    // Full stall, then one pop re-arms
    mode = 2; cfg_settle = 16'd2; cfg_div = 8'd1;
    bus.out_ready = 1'b0;
    at_edge(cyc + 2);
    c0 = cyc;
    for (int w = 0; w < 4; w++) exp_q.push_back(exp_word(c0, 2, 1, w));
    cfg_en = 1'b1;
    at_edge(c0 + 263);
    check("stall_run_in_push", 32'(ent_run), 1);
    at_edge(c0 + 264);
    check("stall_run_drop", 32'(ent_run), 0);
    check("stall_busy", 32'(busy), 0);
    check("stall_valid", 32'(bus.out_valid), 1);
    at_edge(c0 + 270);
    check("stall_hold", 32'(ent_run), 0);
    p = cyc;
    bus.out_ready = 1'b1;
    at_edge(p + 1);
    bus.out_ready = 1'b0;
    c1 = p + 1;
    exp_q.push_back(exp_word(c1, 2, 1, 0));
    check("rearm_idle", 32'(ent_run), 0);
    at_edge(p + 2);
    check("rearm_run", 32'(ent_run), 1);
    bus.out_ready = 1'b1;
    wait_drain("stall_drain", 400);
    cfg_en = 1'b0;
    at_edge(cyc + 3);

    // Repetition-count failure on stuck-at-1
    mode = 1; cfg_settle = 16'd1; cfg_div = 8'd0; cfg_rct_cut = 6'd8;
    at_edge(cyc + 3);
    c0 = cyc;
    cfg_en = 1'b1;
    at_edge(c0 + 10);
    check("rct_pre_fail", 32'(health_fail), 0);
    check("rct_pre_run", 32'(ent_run), 1);
    at_edge(c0 + 11);
    check("rct_fail", 32'(health_fail), 1);
    check("rct_run_off", 32'(ent_run), 0);
    check("rct_busy", 32'(busy), 0);
    cfg_en = 1'b0;
    at_edge(c0 + 14);
    check("rct_sticky", 32'(health_fail), 1);
    check("rct_no_word", 32'(bus.out_valid), 0);
    f = cyc;
    clr_fail = 1'b1;
    at_edge(f + 1);
    clr_fail = 1'b0;
    check("clr_fail", 32'(health_fail), 0);
    check("clr_busy", 32'(busy), 0);
    at_edge(f + 3);
    check("clr_stay_idle", 32'(busy), 0);

    // Abort after 20 samples, then a fresh word
    mode = 2; cfg_settle = 16'd2; cfg_div = 8'd0; cfg_rct_cut = '0;
    bus.out_ready = 1'b1;
    at_edge(cyc + 2);
    c0 = cyc;
    cfg_en = 1'b1;
    at_edge(c0 + 24);
    cfg_en = 1'b0;
    check("abort_pre_run", 32'(ent_run), 1);
    at_edge(c0 + 25);
    check("abort_run", 32'(ent_run), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(bus.out_valid), 0);
    at_edge(cyc + 3);
    c1 = cyc;
    exp_q.push_back(exp_word(c1, 2, 0, 0));
    cfg_en = 1'b1;
    wait_drain("abort_rearm", 200);
    cfg_en = 1'b0;
    at_edge(cyc + 2);

    // Push and pop together at DEPTH-1, then async reset mid-SAMPLE
    mode = 2; cfg_settle = 16'd0; cfg_div = 8'd0;
    bus.out_ready = 1'b0;
    at_edge(cyc + 2);
    c0 = cyc;
    for (int w = 0; w < 4; w++) exp_q.push_back(exp_word(c0, 0, 0, w));
    cfg_en = 1'b1;
    at_edge(c0 + 133);
    bus.out_ready = 1'b1;
    at_edge(c0 + 134);
    bus.out_ready = 1'b0;
    check("pp_run", 32'(ent_run), 1);
    check("pp_busy", 32'(busy), 1);
    check("pp_valid", 32'(bus.out_valid), 1);
    at_edge(c0 + 140);
    check("pp_mid_sample", 32'(ent_run), 1);
    #1;
    resetb = 1'b0;
    exp_q.delete();
    #1;
    check("arst_run", 32'(ent_run), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_valid", 32'(bus.out_valid), 0);
    check("arst_fail", 32'(health_fail), 0);
    check("arst_data", bus.out_data, 0);
    cfg_en = 1'b0;
    at_edge(cyc + 2);
    resetb = 1'b1;
    at_edge(cyc + 3);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_valid", 32'(bus.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
